// File: rtl/noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_output_arbiter
//   Round-robin arbiter for one output port of noc_router. Picks one of the
//   input FIFOs whose head flit targets this output, holds the grant until the
//   flit transfers over out_valid/out_ready, then rotates priority past the
//   winner and re-arbitrates in the same cycle for 1 flit/cycle throughput.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   req        : per-input request (head flit valid and routed here)
//   out_ready  : downstream ready
//   out_valid  : flit presented on the output
//   grant      : one-hot crossbar select, zero when idle
//   grant_idx  : binary index of granted input, zero when idle
//   pop        : one-hot dequeue strobe on transfer
//   proto_err  : sticky, a granted request was withdrawn before transfer
//   busy       : high while a grant is held
//
// Optional build macro NOC_ARB_STATS_EN adds:
//   stats_clr  : synchronous clear of all counters (wins over increment)
//   grant_cnt  : NUM_REQ saturating transfer counters, input i at
//                [i*CNT_BITS +: CNT_BITS]
//   stall_cnt  : saturating count of held cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module noc_output_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [NUM_REQ-1:0]           grant,
  output logic [IDX_BITS-1:0]          grant_idx,
  output logic [NUM_REQ-1:0]           pop,
  output logic                         proto_err,
  output logic                         busy
`ifdef NOC_ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [NUM_REQ*CNT_BITS-1:0]  grant_cnt,
  output logic [CNT_BITS-1:0]          stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [IDX_BITS-1:0]   r_grant_idx, w_grant_idx_nxt;
  logic [IDX_BITS-1:0]   r_ptr, w_ptr_nxt, w_ptr_adv;
  logic                  r_proto_err, w_proto_err_nxt;
  logic                  w_req_held;
  logic                  w_out_valid;
  logic [NUM_REQ-1:0]    w_pop;
  logic [IDX_BITS:0]     w_pick_idle, w_pick_xfer;

  // Returns {found, index} of the first set bit of r scanning upward from
  // base and wrapping modulo NUM_REQ.
  function automatic logic [IDX_BITS:0] pick(input logic [NUM_REQ-1:0]  r,
                                             input logic [IDX_BITS-1:0] base);
    logic                found;
    logic [IDX_BITS-1:0] idx;
    int unsigned         j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(base) + k) % NUM_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = IDX_BITS'(j);
      end
    end
    return {found, idx};
  endfunction

  assign w_req_held = req[r_grant_idx];
  assign w_ptr_adv  = (r_grant_idx == IDX_BITS'(NUM_REQ - 1)) ? '0
                                                              : r_grant_idx + IDX_BITS'(1);
  assign w_pick_idle = pick(req, r_ptr);
  // The input being popped is masked out: its next flit is not yet at the head.
  assign w_pick_xfer = pick(req & ~r_grant, w_ptr_adv);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    w_proto_err_nxt = r_proto_err;
    case (r_state)
      S_IDLE: begin
        if (w_pick_idle[IDX_BITS]) begin
          w_state_nxt     = S_LOCKED;
          w_grant_idx_nxt = w_pick_idle[IDX_BITS-1:0];
          w_grant_nxt     = NUM_REQ'(1) << w_pick_idle[IDX_BITS-1:0];
        end
      end
      S_LOCKED: begin
        if (!w_req_held) begin
          w_state_nxt     = S_IDLE;
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
          w_proto_err_nxt = 1'b1;
        end else if (out_ready) begin
          w_ptr_nxt = w_ptr_adv;
          if (w_pick_xfer[IDX_BITS]) begin
            w_grant_idx_nxt = w_pick_xfer[IDX_BITS-1:0];
            w_grant_nxt     = NUM_REQ'(1) << w_pick_xfer[IDX_BITS-1:0];
          end else begin
            w_state_nxt     = S_IDLE;
            w_grant_nxt     = '0;
            w_grant_idx_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_out_valid = (r_state == S_LOCKED) && w_req_held;
    w_pop       = r_grant & {NUM_REQ{w_out_valid & out_ready}};
    out_valid   = w_out_valid;
    pop         = w_pop;
    grant       = r_grant;
    grant_idx   = r_grant_idx;
    proto_err   = r_proto_err;
    busy        = (r_state == S_LOCKED);
  end

`ifdef NOC_ARB_STATS_EN
  logic [CNT_BITS-1:0] r_grant_cnt [NUM_REQ];
  logic [CNT_BITS-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_pop[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      end
      if (w_out_valid && !out_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_BITS +: CNT_BITS] = r_grant_cnt[i];
    stall_cnt = r_stall_cnt;
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_output_arbiter
//   Self-checking bench for noc_output_arbiter (default parameters). Inputs are
//   driven on the falling edge and outputs sampled 1 time unit later. A
//   transaction-level model (integer grant index, modulo-N pointer) advances on
//   every rising edge and supplies expected values; directed scenarios also
//   compare against literal constants.
// -----------------------------------------------------------------------------
module tb_noc_output_arbiter;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  grant;
  logic [2:0]  grant_idx;
  logic [4:0]  pop;
  logic        proto_err;
  logic        busy;
`ifdef NOC_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [79:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  noc_output_arbiter #(.NUM_REQ(5), .IDX_BITS(3), .CNT_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .pop       (pop),
    .proto_err (proto_err),
    .busy      (busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {out_valid, busy, proto_err, grant, grant_idx, pop};

  // ---------------- reference model ----------------
  bit m_locked;
  bit m_err;
  int m_g;
  int m_ptr;
  int m_w;
  bit m_ov;
`ifdef NOC_ARB_STATS_EN
  int m_cnt [N];
  int m_stall;
`endif

  function automatic int first_from(input logic [4:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_locked = 0; m_err = 0; m_g = 0; m_ptr = 0;
`ifdef NOC_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_stall = 0;
`endif
    end else begin
      m_ov = m_locked && req[m_g];
`ifdef NOC_ARB_STATS_EN
      if (stats_clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_stall = 0;
      end else begin
        if (m_ov && out_ready && m_cnt[m_g] < 65535) m_cnt[m_g]++;
        if (m_ov && !out_ready && m_stall < 65535) m_stall++;
      end
`endif
      if (!m_locked) begin
        m_w = first_from(req, m_ptr);
        if (m_w >= 0) begin m_locked = 1; m_g = m_w; end
      end else if (!req[m_g]) begin
        m_err = 1; m_locked = 0; m_g = 0;
      end else if (out_ready) begin
        m_ptr = (m_g + 1) % N;
        m_w = first_from(req & ~(5'(1) << m_g), m_ptr);
        if (m_w >= 0) m_g = m_w;
        else begin m_locked = 0; m_g = 0; end
      end
    end
  end

  function automatic logic [15:0] exp_vec();
    logic       ov;
    logic [4:0] g;
    logic [4:0] p;
    ov = m_locked && req[m_g];
    g  = m_locked ? (5'(1) << m_g) : 5'd0;
    p  = (ov && out_ready) ? g : 5'd0;
    return {ov, m_locked, m_err, g, 3'(m_g), p};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic [4:0] r, input logic rd);
    @(negedge clk);
    req = r;
    out_ready = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    drive(5'b00000, 1'b0);
    checks++;
    if (dut_vec !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 16'h0000);
    end
    drive(5'b00000, 1'b1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_wrap();
    do_reset();
    drive(5'b10000, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL single_latency got=%b exp=0", out_valid);
    end
    drive(5'b10000, 1'b1);
    checks++;
    if ({out_valid, grant, grant_idx, pop} !== {1'b1, 5'b10000, 3'd4, 5'b10000}) begin
      failures++;
      $display("FAIL single_grant got=%b/%b/%0d/%b exp=1/10000/4/10000", out_valid, grant, grant_idx, pop);
    end
    drive(5'b11111, 1'b0);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL single_bubble got=%b%b exp=00", out_valid, busy);
    end
    drive(5'b11111, 1'b0);
    checks++;
    if (grant_idx !== 3'd0 || grant !== 5'b00001) begin
      failures++; $display("FAIL ptr_after_4 got=%0d exp=0", grant_idx);
    end
    // Transfer from input 3 sets the pointer to 4; 0 must win after wrap.
    do_reset();
    drive(5'b01000, 1'b1);
    drive(5'b01011, 1'b1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL wrap_xfer got=%h exp=%h", dut_vec, exp_vec());
    end
    drive(5'b00011, 1'b1);
    checks++;
    if (grant_idx !== 3'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_grant got=%0d exp=0", grant_idx);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(5'b11111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(5'b11111, 1'b1);
      checks++;
      if (grant_idx !== 3'(k % 5) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_order step=%0d got=%0d/%b exp=%0d/1", k, grant_idx, out_valid, k % 5);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL rr_model step=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(5'b00101, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(5'b00101, 1'b0);
      checks++;
      if (grant !== 5'b00001 || pop !== 5'b00000 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall cyc=%0d got=%b/%b exp=00001/00000", k, grant, pop);
      end
    end
    drive(5'b00101, 1'b1);
    checks++;
    if (pop !== 5'b00001) begin
      failures++; $display("FAIL bp_release got=%b exp=00001", pop);
    end
`ifdef NOC_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt);
    end
`endif
    drive(5'b00101, 1'b1);
    checks++;
    if (grant !== 5'b00100) begin
      failures++; $display("FAIL bp_next got=%b exp=00100", grant);
    end
  endtask

  task automatic test_proto();
    do_reset();
    drive(5'b00100, 1'b0);
    drive(5'b00100, 1'b0);
    checks++;
    if (grant !== 5'b00100) begin
      failures++; $display("FAIL proto_grant got=%b exp=00100", grant);
    end
    drive(5'b00000, 1'b0);
    checks++;
    if ({out_valid, pop, proto_err} !== 7'b0) begin
      failures++; $display("FAIL proto_drop got=%b/%b/%b exp=0/00000/0", out_valid, pop, proto_err);
    end
    drive(5'b11111, 1'b0);
    checks++;
    if ({proto_err, busy, grant} !== {1'b1, 1'b0, 5'b00000}) begin
      failures++; $display("FAIL proto_flag got=%b/%b/%b exp=1/0/00000", proto_err, busy, grant);
    end
    drive(5'b11111, 1'b0);
    checks++;
    if (grant !== 5'b00001 || grant_idx !== 3'd0) begin
      failures++; $display("FAIL proto_ptr got=%b exp=00001", grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(5'b01000, 1'b0);
    drive(5'b01000, 1'b0);
    checks++;
    if (grant !== 5'b01000) begin
      failures++; $display("FAIL rstmid_lock got=%b exp=01000", grant);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pop !== 5'b00000) begin
      failures++; $display("FAIL rstmid_pop got=%b exp=00000", pop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({grant, out_valid, busy, pop} !== 12'b0) begin
      failures++; $display("FAIL rstmid_clear got=%b/%b/%b/%b exp=0", grant, out_valid, busy, pop);
    end
  endtask

`ifdef NOC_ARB_STATS_EN
  task automatic test_stats();
    int n;
    n = 0;
    do_reset();
    for (int c = 0; c < 40 && n < 7; c++) begin
      drive(5'b00010, 1'b1);
      if (pop[1]) n++;
    end
    checks++;
    if (n !== 7) begin
      failures++; $display("FAIL stats_pops got=%0d exp=7", n);
    end
    drive(5'b00010, 1'b1);
    checks++;
    if (grant_cnt[16 +: 16] !== 16'd7) begin
      failures++; $display("FAIL stats_cnt7 got=%0d exp=7", grant_cnt[16 +: 16]);
    end
    drive(5'b00010, 1'b1);
    stats_clr = 1'b1;
    checks++;
    if (pop !== 5'b00010) begin
      failures++; $display("FAIL stats_8th got=%b exp=00010", pop);
    end
    drive(5'b00010, 1'b1);
    stats_clr = 1'b0;
    checks++;
    if (grant_cnt !== 80'd0) begin
      failures++; $display("FAIL stats_clr got=%h exp=0", grant_cnt);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [4:0] r;
    logic [4:0] last_pop;
    last_pop = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = (req & ~(last_pop & 5'($urandom))) | (5'($urandom) & 5'($urandom) & 5'($urandom));
      if ($urandom_range(0, 39) == 0) r = r & 5'($urandom);
      req = r;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 249) != 0);
`ifdef NOC_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 63) == 0);
`endif
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL rand_outputs cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
`ifdef NOC_ARB_STATS_EN
      checks++;
      if (stall_cnt !== 16'(m_stall) || grant_cnt[0 +: 16] !== 16'(m_cnt[0]) ||
          grant_cnt[16 +: 16] !== 16'(m_cnt[1]) || grant_cnt[32 +: 16] !== 16'(m_cnt[2]) ||
          grant_cnt[48 +: 16] !== 16'(m_cnt[3]) || grant_cnt[64 +: 16] !== 16'(m_cnt[4])) begin
        failures++; $display("FAIL rand_stats cyc=%0d got=%h/%0d exp_stall=%0d", c, grant_cnt, stall_cnt, m_stall);
      end
`endif
      last_pop = exp_vec()[4:0];
    end
    rst_n = 1'b1;
`ifdef NOC_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_wrap();
    test_round_robin();
    test_backpressure();
    test_proto();
    test_reset_mid();
`ifdef NOC_ARB_STATS_EN
    test_stats();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Round-robin arbiter for one output port of `noc_router`. One instance per output (N/S/E/W/Local).
- Arbitrates among the input FIFOs whose head flit routes to this output. It holds the grant until the flit transfers over the output valid/ready handshake, then rotates priority.
- Drives the crossbar select and the output `valid`, and returns a per-input pop/dequeue strobe.

Parameters:
- NUM_REQ, 5, number of requesting input ports (index order: 0=N, 1=S, 2=E, 3=W, 4=L)
- IDX_BITS, 3, width of the grant index; must satisfy 2^IDX_BITS >= NUM_REQ
- CNT_BITS, 16, width of the statistics counters (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  per-input request; head flit valid and routed to this output
- out_ready  in  1  downstream ready for this output
- out_valid  out  1  flit presented on this output
- grant  out  NUM_REQ  one-hot crossbar select; all-zero when idle
- grant_idx  out  IDX_BITS  binary index of the granted input; 0 when idle
- pop  out  NUM_REQ  one-hot dequeue strobe, = grant & {NUM_REQ{out_valid & out_ready}}
- proto_err  out  1  sticky flag: a granted request was withdrawn before transfer
- busy  out  1  high in the LOCKED state

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: state=IDLE, grant=0, grant_idx=0, out_valid=0, busy=0, proto_err=0. The priority pointer `ptr` resets to 0.
- States: IDLE, LOCKED. `out_valid` = (state==LOCKED) & req[grant_idx]. `grant` and `grant_idx` are registered.
- Selection function: the first set bit of `req`, scanning from `ptr` upward and wrapping modulo NUM_REQ. The winner is registered.
- IDLE:
  - If req != 0, next cycle state=LOCKED and grant=winner.
  - Latency is exactly 1 cycle from req assertion to out_valid.
- LOCKED, transfer (out_valid & out_ready):
  - pop[grant_idx]=1 for that cycle.
  - ptr <= (grant_idx==NUM_REQ-1) ? 0 : grant_idx+1.
  - Re-arbitrate in the same cycle using the new ptr, with the current granted input excluded from this cycle's selection, since its next flit is not yet valid.
  - If a winner exists, stay LOCKED with the new grant. This gives back-to-back throughput of 1 flit/cycle across different inputs.
  - Otherwise go to IDLE with grant=0.
- LOCKED, stall (out_valid & !out_ready): hold grant, grant_idx and ptr unchanged for any number of cycles.
  - Other requests are ignored; no preemption.
- LOCKED, req[grant_idx]==0 (protocol violation):
  - Set proto_err (sticky until reset).
  - Go to IDLE next cycle, grant=0, ptr unchanged. No pop is issued.
- Wrap-around: with ptr=4 and req=5'b00011, input 0 wins.
- Simultaneous:
  - Requests rising in the same cycle as a transfer are eligible in that cycle's re-arbitration.
  - The same input wins two consecutive flits only when it is the sole requester. After its transfer it must then pass through IDLE, giving 1 bubble cycle.
- Reset mid-operation: on the next clk edge all state returns to reset values. Any in-flight grant is dropped with no pop.
- Fairness: with all inputs continuously requesting and out_ready=1, grants rotate 0,1,2,3,4,0,...
  - Maximum wait for any requester is NUM_REQ-1 transfers.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - Adds `grant_cnt` output (NUM_REQ*CNT_BITS, flattened, input i at bits [i*CNT_BITS +: CNT_BITS]). Each counter increments on pop[i] and saturates at all-ones.
  - Adds `stall_cnt` output (CNT_BITS), which counts LOCKED cycles with out_valid & !out_ready and saturates.
  - Adds `stats_clr` input (1): synchronous clear of all counters; clear wins over increment in the same cycle.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single request, wrap-around ptr:
  - Stimulus: reset, then req=5'b10000 held, out_ready=1.
  - Required: out_valid rises 1 cycle later with grant=5'b10000, grant_idx=4; pop[4] pulses; ptr=0 afterwards.
- Round-robin order:
  - Stimulus: req=5'b11111 held, out_ready=1 for 10 cycles.
  - Required: grant_idx sequence 0,1,2,3,4,0,1,2,3,4 with no bubbles after the first grant.
- Backpressure:
  - Stimulus: req=5'b00101, out_ready=0 for 5 cycles, then 1.
  - Required: grant stays 5'b00001 throughout the stall with pop=0; on release pop[0]=1, then grant moves to 5'b00100 the next cycle.
  - With NOC_ARB_STATS_EN: stall_cnt=5.
- Protocol violation:
  - Stimulus: grant input 2, then drop req[2] while out_ready=0.
  - Required: proto_err=1 and state IDLE next cycle with grant=0; ptr unchanged, so a following req=5'b11111 grants input 0.
- Reset mid-stall:
  - Stimulus: rst_n=0 for 1 cycle while LOCKED on input 3.
  - Required: grant=0, out_valid=0, busy=0 after the edge, and no pop issued.
- Stats (NOC_ARB_STATS_EN):
  - Stimulus: 7 transfers from input 1, then stats_clr=1 asserted in the same cycle as an 8th transfer.
  - Required: grant_cnt[1]=7 before the clear and 0 after.
